adder_operand_collector: RTL and testbench

- Upstream issue stage for the tile's combinational full_adder.
- Collects operands A, B and, optionally, a carry from neighbour channels using valid/ready handshakes, then holds them stable and drives the adder's a/b/carry_in/carry_listen/on_off inputs.
- Checks the adder's ack and registers {carry_out, c} into a result channel for the downstream tile.

---
 rtl/tile_pkg.sv | 22 ++
 rtl/operand_slot.sv | 45 ++++
 rtl/adder_operand_collector.sv | 195 +++++++++++++++++++
 tb/tb_adder_operand_collector.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared types and defaults for the adder tile.
// Contents:
//   state_t   - operand collector FSM states (COLLECT, FIRE, HOLD)
//   result_t  - {carry, sum} result word at the default width
//   DEFAULT_WIDTH, DEFAULT_ACK_TIMEOUT - default block parameters
package tile_pkg;

  localparam int DEFAULT_WIDTH       = 16;
  localparam int DEFAULT_ACK_TIMEOUT = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FIRE    = 2'd1,
    HOLD    = 2'd2
  } state_t;

  typedef struct packed {
    logic                     carry;
    logic [DEFAULT_WIDTH-1:0] sum;
  } result_t;

endpackage

// File: rtl/operand_slot.sv
// One-entry operand buffer with a full flag.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   in_valid/in_data  - upstream offer
//   in_ready          - ~full; a transfer happens on in_valid && in_ready
//   clear             - drops the full flag (operand consumed)
//   full, data        - stored operand
//   capture           - high in the cycle a transfer is accepted
module operand_slot #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         clear,
  output logic         full,
  output logic [W-1:0] data,
  output logic         capture
);

  logic         full_reg;
  logic [W-1:0] data_reg;

  assign in_ready = ~full_reg;
  assign capture  = in_valid & ~full_reg;
  assign full     = full_reg;
  assign data     = data_reg;

  // clear only hits a full slot and capture only an empty one, so the two
  // never collide on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (clear) begin
      full_reg <= 1'b0;
    end else if (capture) begin
      full_reg <= 1'b1;
      data_reg <= in_data;
    end
  end

endmodule

// File: rtl/adder_operand_collector.sv
// Issue stage for the tile's combinational full adder.
// Collects A, B and (when cfg_carry_listen=1) a carry operand over
// valid/ready channels, drives the adder while in FIRE, and registers
// {carry_out, sum} onto the result channel.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   cfg_enable, cfg_carry_listen    - tile enable, carry operand required
//   a_*, b_*, cin_*                 - operand channels (valid/data/ready)
//   add_a, add_b, add_carry_in,
//   add_carry_listen, add_on_off    - adder drive, zero outside FIRE
//   add_c, add_carry_out, add_ack   - adder response
//   res_valid/res_data/res_ready    - result channel, res_data={carry,sum}
//   err                             - sticky ack-timeout flag
//   perf_ops, perf_stall            - saturating counters, only present when
//                                     ADDER_COLLECT_PERF_EN is defined
module adder_operand_collector
  import tile_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
`ifdef ADDER_COLLECT_PERF_EN
  , parameter int CNT_W     = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_enable,
  input  logic             cfg_carry_listen,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  input  logic             cin_valid,
  input  logic             cin_data,
  output logic             cin_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_carry_in,
  output logic             add_carry_listen,
  output logic             add_on_off,
  input  logic [WIDTH-1:0] add_c,
  input  logic             add_carry_out,
  input  logic             add_ack,
  output logic             res_valid,
  output logic [WIDTH:0]   res_data,
  input  logic             res_ready,
  output logic             err
`ifdef ADDER_COLLECT_PERF_EN
  , output logic [CNT_W-1:0] perf_ops
  , output logic [CNT_W-1:0] perf_stall
`endif
);

  localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic              listen_reg, listen_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [WIDTH:0]    res_reg, res_next;
  logic              err_reg, err_next;
  logic              clr_a, clr_b, clr_cin;

  logic             a_full, b_full, cin_full;
  logic             a_cap, b_cap, cin_cap;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;

  operand_slot #(.W(WIDTH)) u_slot_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .clear(clr_a), .full(a_full), .data(a_q),
    .capture(a_cap)
  );

  operand_slot #(.W(WIDTH)) u_slot_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .clear(clr_b), .full(b_full), .data(b_q),
    .capture(b_cap)
  );

  // The carry slot keeps accepting while a listen=0 op is in FIRE; it is
  // not part of that op, so the buffered carry waits for a listen=1 op.
  operand_slot #(.W(1)) u_slot_cin (
    .clk(clk), .reset(reset), .in_valid(cin_valid), .in_data(cin_data),
    .in_ready(cin_ready), .clear(clr_cin), .full(cin_full), .data(cin_q),
    .capture(cin_cap)
  );

  // Count operands arriving on this edge as present so FIRE starts the
  // cycle right after the last operand is accepted.
  logic can_fire;
  always_comb begin
    can_fire = cfg_enable & (a_full | a_cap) & (b_full | b_cap) &
               (~cfg_carry_listen | cin_full | cin_cap);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= COLLECT;
      listen_reg <= 1'b0;
      wait_reg   <= '0;
      res_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      listen_reg <= listen_next;
      wait_reg   <= wait_next;
      res_reg    <= res_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    listen_next = listen_reg;
    wait_next   = wait_reg;
    res_next    = res_reg;
    err_next    = err_reg;
    clr_a       = 1'b0;
    clr_b       = 1'b0;
    clr_cin     = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (can_fire) begin
          state_next  = FIRE;
          listen_next = cfg_carry_listen;
          wait_next   = '0;
        end
      end
      FIRE: begin
        if (add_ack) begin
          res_next   = {add_carry_out, add_c};
          clr_a      = 1'b1;
          clr_b      = 1'b1;
          clr_cin    = listen_reg;
          state_next = HOLD;
        end else if (wait_reg == WAIT_LAST) begin
          // Give up: drop the operands and report, no result is produced.
          err_next   = 1'b1;
          clr_a      = 1'b1;
          clr_b      = 1'b1;
          clr_cin    = listen_reg;
          state_next = COLLECT;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      HOLD: begin
        if (res_ready) begin
          if (can_fire) begin
            state_next  = FIRE;
            listen_next = cfg_carry_listen;
            wait_next   = '0;
          end else begin
            state_next = COLLECT;
          end
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  logic firing;
  assign firing           = (state_reg == FIRE);
  assign add_on_off       = firing;
  assign add_a            = firing ? a_q : '0;
  assign add_b            = firing ? b_q : '0;
  assign add_carry_listen = firing & listen_reg;
  assign add_carry_in     = firing & listen_reg & cin_q;
  assign res_valid        = (state_reg == HOLD);
  assign res_data         = res_reg;
  assign err              = err_reg;

`ifdef ADDER_COLLECT_PERF_EN
  logic [CNT_W-1:0] perf_ops_reg, perf_stall_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops_reg   <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (state_reg == HOLD && res_ready && perf_ops_reg != '1)
        perf_ops_reg <= perf_ops_reg + 1'b1;
      if (state_reg == HOLD && !res_ready && perf_stall_reg != '1)
        perf_stall_reg <= perf_stall_reg + 1'b1;
    end
  end

  assign perf_ops   = perf_ops_reg;
  assign perf_stall = perf_stall_reg;
`endif

endmodule

// File: tb/tb_adder_operand_collector.sv
module tb_adder_operand_collector;
  import tile_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_enable, cfg_carry_listen;
  logic        a_valid, b_valid, cin_valid, cin_data;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready, cin_ready;
  logic [15:0] add_a, add_b, add_c;
  logic        add_carry_in, add_carry_listen, add_on_off;
  logic        add_carry_out, add_ack;
  logic        res_valid, res_ready, err;
  logic [16:0] res_data;
  logic        ack_en;
`ifdef ADDER_COLLECT_PERF_EN
  logic [15:0] perf_ops, perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the full adder.
  assign {add_carry_out, add_c} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_carry_in};
  assign add_ack = ack_en & add_on_off;

  adder_operand_collector dut (
    .clk(clk), .reset(reset),
    .cfg_enable(cfg_enable), .cfg_carry_listen(cfg_carry_listen),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .cin_valid(cin_valid), .cin_data(cin_data), .cin_ready(cin_ready),
    .add_a(add_a), .add_b(add_b), .add_carry_in(add_carry_in),
    .add_carry_listen(add_carry_listen), .add_on_off(add_on_off),
    .add_c(add_c), .add_carry_out(add_carry_out), .add_ack(add_ack),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .err(err)
`ifdef ADDER_COLLECT_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs expected right after a reset edge.
  task automatic chk_idle(input string tag);
    chk(32'(dut.state_reg), 32'(COLLECT), {tag, "_state"});
    chk({add_on_off, add_carry_listen, add_carry_in, res_valid, err}, 0, {tag, "_ctl"});
    chk({add_a, add_b}, 0, {tag, "_adddata"});
    chk(32'(res_data), 0, {tag, "_res"});
    chk({a_ready, b_ready, cin_ready}, 3'b111, {tag, "_ready"});
  endtask

  // Offer operands for one cycle, expect FIRE next cycle and the result the
  // cycle after, then drain it.
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic send_cin,
                    input logic cin, input logic [16:0] exp, input string tag);
    a_valid = 1'b1; a_data = a;
    b_valid = 1'b1; b_data = b;
    cin_valid = send_cin; cin_data = cin;
    tick();
    a_valid = 1'b0; b_valid = 1'b0; cin_valid = 1'b0;
    chk({add_on_off, add_carry_listen}, {1'b1, cfg_carry_listen}, {tag, "_fire"});
    chk(32'(add_a), 32'(a), {tag, "_add_a"});
    tick();
    chk(32'(res_valid), 1, {tag, "_rv"});
    chk(32'(res_data), 32'(exp), {tag, "_res"});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk(32'(res_valid), 0, {tag, "_drain"});
  endtask

  initial begin
    reset = 1'b1; cfg_enable = 1'b1; cfg_carry_listen = 1'b0;
    a_valid = 0; b_valid = 0; cin_valid = 0; a_data = 0; b_data = 0; cin_data = 0;
    res_ready = 0; ack_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_idle("reset");

    // listen=0: offered carry is buffered but not used
    cfg_carry_listen = 1'b0;
    op(16'h1234, 16'h5678, 1'b1, 1'b1, 17'h068AC, "l0");
    chk(32'(cin_ready), 0, "l0_cin_kept");

    // listen=1: buffered carry consumed, then explicit carry 0
    cfg_carry_listen = 1'b1;
    op(16'h1234, 16'h5678, 1'b0, 1'b0, 17'h068AD, "l1_c1");
    chk(32'(cin_ready), 1, "l1_cin_used");
    op(16'h1234, 16'h5678, 1'b1, 1'b0, 17'h068AC, "l1_c0");
    op(16'hFFFF, 16'h0001, 1'b1, 1'b1, 17'h10001, "wrap_c1");
    op(16'hFFFF, 16'h0001, 1'b1, 1'b0, 17'h10000, "wrap_c0");
    op(16'h0000, 16'h0000, 1'b1, 1'b1, 17'h00001, "zero_c1");

    // backpressure: result held 5 cycles while next operands wait
    cfg_carry_listen = 1'b0;
    a_valid = 1; a_data = 16'h0001; b_valid = 1; b_data = 16'h0002;
    tick();
    a_valid = 0; b_valid = 0;
    tick();
    chk(32'(res_data), 32'h00003, "stall_first");
    a_valid = 1; a_data = 16'h0003; b_valid = 1; b_data = 16'h0004;
    for (int i = 0; i < 5; i++) begin
      tick();
      a_valid = 0; b_valid = 0;
      chk(32'(res_data), 32'h00003, $sformatf("stall_hold%0d", i));
      chk({a_ready, b_ready}, 2'b00, $sformatf("stall_ready%0d", i));
    end
`ifdef ADDER_COLLECT_PERF_EN
    chk(32'(perf_stall), 5, "perf_stall");
`endif
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk(32'(dut.state_reg), 32'(FIRE), "release_fire");
    chk(32'(add_a), 32'h3, "release_add_a");
`ifdef ADDER_COLLECT_PERF_EN
    chk(32'(perf_ops), 7, "perf_ops");
`endif
    tick();
    chk(32'(res_data), 32'h00007, "release_res");
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // ack timeout
    ack_en = 1'b0;
    a_valid = 1; a_data = 16'h0010; b_valid = 1; b_data = 16'h0020;
    tick();
    a_valid = 0; b_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({dut.state_reg == FIRE, res_valid, err}, 3'b100, $sformatf("to_wait%0d", i));
    end
    tick();
    chk({res_valid, err}, 2'b01, "to_err");
    chk(32'(dut.state_reg), 32'(COLLECT), "to_state");
    chk({a_ready, b_ready}, 2'b11, "to_ready");
    ack_en = 1'b1;
    op(16'h0002, 16'h0003, 1'b0, 1'b0, 17'h00005, "after_to");
    chk(32'(err), 1, "err_sticky");

    // reset during FIRE
    a_valid = 1; a_data = 16'h0100; b_valid = 1; b_data = 16'h0200;
    tick();
    a_valid = 0; b_valid = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("rst_fire");
    tick();
    chk(32'(res_valid), 0, "rst_fire_nores");

    // reset during HOLD
    a_valid = 1; a_data = 16'h0100; b_valid = 1; b_data = 16'h0200;
    tick();
    a_valid = 0; b_valid = 0;
    tick();
    chk(32'(res_valid), 1, "pre_rst_hold");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("rst_hold");
`ifdef ADDER_COLLECT_PERF_EN
    chk({perf_ops, perf_stall}, 0, "rst_perf");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
